// File: rtl/sound_pkg.sv
// Shared types and constants for the buzzer arbiter.
// No logic; pure definitions.
// No flow control.
package sound_pkg;

    localparam int HALF_W = 16;
    localparam int MS_W   = 8;

    localparam logic [1:0] SRC_WALL  = 2'd0;
    localparam logic [1:0] SRC_PAD   = 2'd1;
    localparam logic [1:0] SRC_POWER = 2'd2;
    localparam logic [1:0] SRC_LOSS  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Fixed priority: loss > power > pad > wall (pending bit index == source code)
    function automatic logic [1:0] pick_src(input logic [3:0] pend);
        if (pend[SRC_LOSS])       return SRC_LOSS;
        else if (pend[SRC_POWER]) return SRC_POWER;
        else if (pend[SRC_PAD])   return SRC_PAD;
        else                      return SRC_WALL;
    endfunction

endpackage

// File: rtl/sound_arbiter_tone_gen.sv
// Square-wave generator: toggles its output every `half` cycles while run is high.
// First toggle lands `half` cycles after run rises; clears on the edge run is low.
// No backpressure; run=0 holds the output low and the counter at zero.
module tone_gen
    import sound_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [HALF_W-1:0] half,
    output logic              wave
);

    logic [HALF_W-1:0] cnt;

    // Half-period counter; the wave flips each time the counter wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt == half - 1'b1) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sound_arbiter.sv
// Buzzer arbiter: latches one-shot audio requests, plays them by priority as tone+gap bursts.
// Request sampled at edge n is granted at edge n+1; tone/gap lengths counted in tick_ms pulses.
// No backpressure: repeated requests of a pending source merge; a loss preempts any other source.
module sound_arbiter
    import sound_pkg::*;
#(
    parameter logic [HALF_W-1:0] PAD_HALF   = 16'd1500,
    parameter logic [HALF_W-1:0] WALL_HALF  = 16'd3000,
    parameter logic [HALF_W-1:0] POWER_HALF = 16'd1000,
    parameter logic [HALF_W-1:0] LOSS1_HALF = 16'd4000,
    parameter logic [HALF_W-1:0] LOSS2_HALF = 16'd6000,
    parameter logic [MS_W-1:0]   TONE_MS    = 8'd60,
    parameter logic [MS_W-1:0]   GAP_MS     = 8'd20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_ms,
    input  logic       mute,
    input  logic       req_pad,
    input  logic       req_wall,
    input  logic       req_power,
    input  logic       req_loss,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] cur_src
);

    state_t            state;
    logic [3:0]        pend;
    logic [HALF_W-1:0] half_q;
    logic [MS_W-1:0]   ms_cnt;
    logic              second_note;

    logic [3:0]        req_vec;
    logic [1:0]        win;
    logic [HALF_W-1:0] win_half;
    logic [3:0]        clr;
    logic              preempt;
    logic              grant;
    logic              tone_end;
    logic              gap_end;
    logic              run;
    logic              wave;

    assign req_vec = {req_loss, req_power, req_pad, req_wall};

    // Winner selection, grant/preempt decisions and tone-generator enable
    always_comb begin
        win      = pick_src(pend);
        win_half = WALL_HALF;
        case (win)
            SRC_LOSS:  win_half = LOSS1_HALF;
            SRC_POWER: win_half = POWER_HALF;
            SRC_PAD:   win_half = PAD_HALF;
            default:   win_half = WALL_HALF;
        endcase
        // When preempting, pend[SRC_LOSS] is set so win is always the loss source
        preempt  = (state != IDLE) && pend[SRC_LOSS] && (cur_src != SRC_LOSS);
        grant    = ((state == IDLE) && (|pend)) || preempt;
        clr      = 4'b0000;
        if (grant) clr[win] = 1'b1;
        tone_end = (state == TONE) && tick_ms && (ms_cnt == TONE_MS - 8'd1);
        gap_end  = (state == GAP) &&
                   ((GAP_MS == 8'd0) || (tick_ms && (ms_cnt == GAP_MS - 8'd1)));
        // Drop run on the leaving edge so the wave is already low when GAP/next tone starts
        run      = (state == TONE) && !tone_end && !preempt;
    end

    // Pending bits and the IDLE/TONE/GAP sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pend        <= 4'b0000;
            cur_src     <= SRC_WALL;
            half_q      <= '0;
            ms_cnt      <= '0;
            second_note <= 1'b0;
        end else begin
            // A request on the granting edge re-sets the bit (set beats clear)
            pend <= (pend & ~clr) | req_vec;
            if (grant) begin
                state       <= TONE;
                cur_src     <= win;
                half_q      <= win_half;
                ms_cnt      <= '0;
                second_note <= (win == SRC_LOSS);
            end else begin
                case (state)
                    TONE: begin
                        if (tone_end) begin
                            state  <= GAP;
                            ms_cnt <= '0;
                        end else if (tick_ms) begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            ms_cnt <= '0;
                            if (second_note) begin
                                state       <= TONE;
                                half_q      <= LOSS2_HALF;
                                second_note <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (tick_ms) begin
                            ms_cnt <= ms_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    tone_gen u_tone_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .half  (half_q),
        .wave  (wave)
    );

    assign buzzer = wave & ~mute;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_sound_arbiter.sv
module tb_sound_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_ms;
    logic       mute;
    logic       req_pad, req_wall, req_power, req_loss;
    logic       buzzer, busy;
    logic [1:0] cur_src;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    typedef struct {
        int src;
        int rises;
        int period;
    } tone_t;
    tone_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sound_arbiter #(
        .PAD_HALF   (16'd4),
        .WALL_HALF  (16'd6),
        .POWER_HALF (16'd3),
        .LOSS1_HALF (16'd8),
        .LOSS2_HALF (16'd12),
        .TONE_MS    (8'd2),
        .GAP_MS     (8'd1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_ms   (tick_ms),
        .mute      (mute),
        .req_pad   (req_pad),
        .req_wall  (req_wall),
        .req_power (req_power),
        .req_loss  (req_loss),
        .buzzer    (buzzer),
        .busy      (busy),
        .cur_src   (cur_src)
    );

    // tick_ms is sampled high at every edge whose number is a multiple of 50
    function automatic int nxt(int e);
        return (e / 50 + 1) * 50;
    endfunction
    // A tone entered at edge e ends on the second tick strictly after e
    function automatic int tick2(int e);
        return nxt(nxt(e));
    endfunction
    // Rising edges at e+half*(2j+1) strictly before e+d
    function automatic int rises(int half, int d);
        if (d > half) return (d - 1 - half) / (2 * half) + 1;
        return 0;
    endfunction

    task automatic push_tone(int src, int r, int half);
        tone_t t;
        t.src    = src;
        t.rises  = r;
        t.period = (r >= 2) ? 2 * half : 0;
        exp_q.push_back(t);
    endtask

    task automatic chk(string tag, int obs, int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        tick_ms = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_ms = ((cyc + 1) % 50 == 0);
        end
    end

    task automatic to_edge(int k);
        if (cyc > k) chk("schedule", cyc, k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] v, output int n);
        {req_loss, req_power, req_pad, req_wall} = v;
        n = cyc + 1;
        @(posedge clk);
        #1;
        {req_loss, req_power, req_pad, req_wall} = 4'b0000;
    endtask

    // Monitor: group buzzer rises into tones and compare each against the scoreboard
    bit in_tone = 0;
    bit t_bad;
    int t_src, t_rises, t_last, t_period;
    logic prev_buz = 1'b0;

    task automatic close_tone();
        tone_t t;
        in_tone = 0;
        chk("tone_present", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            chk("tone_src", t_src, t.src);
            chk("tone_rises", t_rises, t.rises);
            chk("tone_period", t_bad ? -1 : t_period, t.period);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (in_tone && (busy !== 1'b1 || int'(cur_src) != t_src ||
                            (buzzer === 1'b0 && cyc - t_last > 30)))
                close_tone();
            if (buzzer === 1'b1 && prev_buz !== 1'b1) begin
                if (!in_tone) begin
                    in_tone  = 1;
                    t_src    = int'(cur_src);
                    t_rises  = 1;
                    t_last   = cyc;
                    t_period = 0;
                    t_bad    = 0;
                end else begin
                    if (t_rises == 1) t_period = cyc - t_last;
                    else if (cyc - t_last != t_period) t_bad = 1;
                    t_rises++;
                    t_last = cyc;
                end
            end
            prev_buz = buzzer;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n, e, x, e1, x1, e2, x2, ep, xp, k;
        int seen;
        rst_n = 1'b1;
        mute  = 1'b0;
        {req_loss, req_power, req_pad, req_wall} = 4'b0000;
        #2 rst_n = 1'b0;
        #2;
        chk("reset_buzzer", buzzer, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cur_src", cur_src, 0);
        to_edge(5);
        rst_n = 1'b1;
        to_edge(8);
        chk("post_reset_busy", busy, 0);

        // 1: single pad request
        to_edge(120);
        pulse(4'b0010, n);
        chk("s1_busy_at_req", busy, 0);
        e = n + 1;
        x = tick2(e);
        push_tone(1, rises(4, x - e), 4);
        to_edge(e);
        chk("s1_busy", busy, 1);
        chk("s1_src", cur_src, 1);
        to_edge(e + 3);
        chk("s1_buz_before_rise", buzzer, 0);
        to_edge(e + 4);
        chk("s1_first_rise", buzzer, 1);
        to_edge(x + 1);
        chk("s1_gap_silent", buzzer, 0);
        to_edge(x + 49);
        chk("s1_busy_in_gap", busy, 1);
        to_edge(x + 50);
        chk("s1_busy_end", busy, 0);

        // 2: wall and pad together, pad first
        to_edge(x + 60);
        pulse(4'b0011, n);
        e = n + 1;
        x = tick2(e);
        push_tone(1, rises(4, x - e), 4);
        e1 = x + 51;
        x1 = tick2(e1);
        push_tone(0, rises(6, x1 - e1), 6);
        to_edge(e);
        chk("s2_src_pad", cur_src, 1);
        to_edge(x + 50);
        chk("s2_idle_between", busy, 0);
        to_edge(e1);
        chk("s2_busy_wall", busy, 1);
        chk("s2_src_wall", cur_src, 0);
        to_edge(x1 + 50);
        chk("s2_busy_end", busy, 0);

        // 3: loss preempts a pad tone, two-note cue, pad dropped
        to_edge(x1 + 60);
        pulse(4'b0010, n);
        e = n + 1;
        to_edge(e + 10);
        pulse(4'b1000, n);
        e1 = n + 1;
        push_tone(1, rises(4, e1 - e), 4);
        x1 = tick2(e1);
        push_tone(3, rises(8, x1 - e1), 8);
        e2 = x1 + 50;
        x2 = tick2(e2);
        push_tone(3, rises(12, x2 - e2), 12);
        to_edge(e1);
        chk("s3_src_loss", cur_src, 3);
        chk("s3_abort_buz", buzzer, 0);
        to_edge(e2);
        chk("s3_note2_busy", busy, 1);
        chk("s3_note2_src", cur_src, 3);
        to_edge(x2 + 50);
        chk("s3_busy_end", busy, 0);
        to_edge(x2 + 55);
        chk("s3_no_pad_replay", busy, 0);

        // 4: three power pulses during a wall tone collapse to one play
        to_edge(x2 + 100);
        pulse(4'b0001, n);
        e = n + 1;
        x = tick2(e);
        push_tone(0, rises(6, x - e), 6);
        for (int i = 0; i < 3; i++) begin
            to_edge(e + 5 + 10 * i);
            pulse(4'b0100, n);
        end
        ep = x + 51;
        xp = tick2(ep);
        push_tone(2, rises(3, xp - ep), 3);
        to_edge(ep);
        chk("s4_src_power", cur_src, 2);
        to_edge(xp + 50);
        chk("s4_busy_end", busy, 0);
        to_edge(xp + 80);
        chk("s4_single_play", busy, 0);

        // 5: mute during the first 50 cycles of a pad tone
        k = nxt(cyc);
        to_edge(k);
        mute = 1'b1;
        pulse(4'b0010, n);
        e = n + 1;
        x = tick2(e);
        push_tone(1, rises(4, x - e) - 6, 4);
        seen = 0;
        for (int c = e; c < e + 50; c++) begin
            to_edge(c);
            if (c == e) begin
                chk("s5_busy", busy, 1);
                chk("s5_src", cur_src, 1);
            end
            seen = seen | int'(buzzer);
        end
        chk("s5_muted_silent", seen, 0);
        mute = 1'b0;
        to_edge(e + 51);
        chk("s5_phase_low", buzzer, 0);
        to_edge(e + 52);
        chk("s5_phase_rise", buzzer, 1);
        to_edge(x + 49);
        chk("s5_busy_in_gap", busy, 1);
        to_edge(x + 50);
        chk("s5_busy_end", busy, 0);

        // 6: reset during loss note 2 with a wall request pending
        k = nxt(cyc);
        to_edge(k);
        pulse(4'b1000, n);
        e1 = n + 1;
        x1 = tick2(e1);
        push_tone(3, rises(8, x1 - e1), 8);
        e2 = x1 + 50;
        push_tone(3, rises(12, 21), 12);
        to_edge(e2 + 10);
        pulse(4'b0001, n);
        to_edge(e2 + 20);
        chk("s6_before_reset_src", cur_src, 3);
        rst_n = 1'b0;
        #1;
        chk("s6_reset_buzzer", buzzer, 0);
        chk("s6_reset_busy", busy, 0);
        chk("s6_reset_src", cur_src, 0);
        to_edge(e2 + 23);
        rst_n = 1'b1;
        seen = 0;
        for (int c = e2 + 24; c < e2 + 224; c++) begin
            to_edge(c);
            seen = seen | int'(busy) | int'(buzzer);
        end
        chk("s6_pending_lost", seen, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
